lsu_stage: RTL
==============

// Module: lsu_stage
// PURPOSE
//  Memory-access stage directly downstream of the ALU. Takes the ALU result (effective address or
//  pass-through value) plus store data, performs one load/store on a simple req/ack data-memory
//  port with byte-lane steering and sign extension, then hands one result to write-back.
//  Non-memory instructions bypass the memory port with fixed latency.
// PARAMETERS
//  TIMEOUT_CYC  16  max cycles in REQ waiting for mem_ack before aborting with lsu_err (>=1)
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  rst_n        in   1   reset, asynchronous assert, active-low
//  alu_valid    in   1   ALU result valid (ALU_done); sampled only when lsu_ready=1
//  lsu_ready    out  1   stage idle, accepts a new op this cycle
//  alu_result   in   32  effective address (mem op) or value to forward (non-mem op)
//  store_data   in   32  rs2 value for stores
//  funct3       in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  mem_ren      in   1   op is a load
//  mem_wen      in   1   op is a store
//  mem_req      out  1   memory request, held until ack
//  mem_we       out  1   1=write, 0=read; valid with mem_req
//  mem_addr     out  32  word-aligned address {alu_result[31:2],2'b00}
//  mem_wdata    out  32  store data replicated into lanes
//  mem_wmask    out  4   byte write strobes
//  mem_ack      in   1   memory completes request this cycle; mem_rdata valid with it
//  mem_rdata    in   32  read word
//  lsu_valid    out  1   one-cycle pulse: lsu_result/lsu_err valid
//  lsu_result   out  32  load data (extended) or forwarded alu_result; 0 on error
//  lsu_err      out  1   misaligned, ren&wen both set, or timeout; valid with lsu_valid
// BEHAVIOUR
//  - Reset (rst_n low, async): state IDLE, timeout counter 0, mem_req/mem_we/lsu_valid/lsu_err=0,
//    mem_addr/mem_wdata/lsu_result=0, mem_wmask=0. Reset mid-op drops mem_req immediately; no lsu_valid.
//  - lsu_ready = (state==IDLE), combinational; all other outputs registered.
//  - FSM IDLE -> REQ -> DONE -> IDLE; IDLE -> DONE directly for bypass/error.
//  - IDLE & alu_valid: latch alu_result, store_data, funct3, ren, wen.
//    * ren=wen=0: lsu_result<=alu_result, go DONE (lsu_valid 1 cycle after accept).
//    * ren&wen, H/HU with addr[0]=1, or W with addr[1:0]!=0: no mem_req, DONE with lsu_err=1, result 0.
//    * else: go REQ, drive mem_req=1, mem_we=wen, mem_addr, wdata, wmask.
//  - Store lanes (a=addr[1:0]): B mask 0001<<a, wdata {4{sd[7:0]}}; H mask 0011<<a, wdata {2{sd[15:0]}};
//    W mask 1111, wdata sd. Loads drive mem_wmask=0. Unused funct3 (011,11x) on a mem op -> lsu_err.
//  - REQ: mem_* held stable until mem_ack=1 sampled; that edge: mem_req<=0, capture load data, go DONE.
//    Counter increments each REQ cycle; reaching TIMEOUT_CYC without ack: mem_req<=0, lsu_err=1, DONE.
//    Ack on the same edge the counter expires: ack wins, no error.
//  - Load extend: byte = rdata[8a+7:8a], half = rdata[16a[1]+15:16a[1]]; B/H sign-extend, BU/HU zero-extend.
//    Stores complete with lsu_result=0, lsu_err=0.
//  - DONE: lsu_valid=1 exactly one cycle, then IDLE; lsu_result/lsu_err hold until next DONE.
//  - mem_ack outside REQ ignored. alu_valid while not ready ignored (upstream must hold it).
//  - Best-case latency: bypass 1 cycle, load/store with same-cycle ack 2 cycles from accept to lsu_valid.
// TESTING
//  - Bypass: alu_valid, ren=wen=0, alu_result=0x1234_5678 -> next cycle lsu_valid=1, result 0x12345678, no mem_req.
//  - LB addr=0x103, mem_rdata=0x80AA_BBCC ack after 3 cycles -> mem_addr=0x100, result 0xFFFF_FF80, err=0.
//  - SH addr=0x202, store_data=0xDEAD_BEEF -> mem_we=1, wmask=1100, wdata=0xBEEF_BEEF; ack -> lsu_valid, result 0.
//  - LW addr=0x101 -> no mem_req, lsu_valid next cycle with lsu_err=1, result 0.
//  - LHU, mem_ack never asserted, TIMEOUT_CYC=16 -> mem_req drops after 16 cycles, lsu_valid with lsu_err=1.
//  - rst_n low while in REQ -> mem_req=0 same cycle, lsu_ready=1, no lsu_valid; next op works normally.

Source files
------------

// File: rtl/lsu_stage.sv
// rtl/lsu_stage.sv - memory-access stage: one load/store per op on a req/ack port, bypass otherwise
module lsu_stage #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  output logic        lsu_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [2:0]  funct3,
  input  logic        mem_ren,
  input  logic        mem_wen,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        lsu_valid,
  output logic [31:0] lsu_result,
  output logic        lsu_err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    f3_q;
  logic [1:0]    a_q;
  logic          ren_q;

  logic [1:0]    a_in;
  logic          bad_f3;
  logic          misal;
  logic          op_err;
  logic [3:0]    wmask_in;
  logic [31:0]   wdata_in;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_val;

  assign lsu_ready = (state == IDLE);
  assign a_in      = alu_result[1:0];
  assign bad_f3    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
  assign misal     = ((funct3[1:0] == 2'b01) && a_in[0]) ||
                     ((funct3[1:0] == 2'b10) && (a_in != 2'b00));
  assign op_err    = (mem_ren && mem_wen) || ((mem_ren || mem_wen) && (bad_f3 || misal));

  // Store lane steering: strobes follow the byte offset, data is replicated into every lane
  always_comb begin
    wmask_in = 4'b0000;
    wdata_in = store_data;
    case (funct3[1:0])
      2'b00: begin
        wmask_in = 4'b0001 << a_in;
        wdata_in = {4{store_data[7:0]}};
      end
      2'b01: begin
        wmask_in = 4'b0011 << a_in;
        wdata_in = {2{store_data[15:0]}};
      end
      default: begin
        wmask_in = 4'b1111;
        wdata_in = store_data;
      end
    endcase
    if (!mem_wen) wmask_in = 4'b0000;
  end

  // Load lane selection and sign/zero extension of the returned word
  always_comb begin
    rd_byte = mem_rdata[7:0];
    case (a_q)
      2'd0: rd_byte = mem_rdata[7:0];
      2'd1: rd_byte = mem_rdata[15:8];
      2'd2: rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
    rd_half  = a_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_val = mem_rdata;
    case (f3_q)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_val = {24'h0, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_val = {16'h0, rd_half};
      default: load_val = mem_rdata;
    endcase
  end

  // Stage FSM: accept, optional memory handshake with timeout, one-cycle result pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      f3_q       <= 3'b000;
      a_q        <= 2'b00;
      ren_q      <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_wmask  <= 4'h0;
      lsu_valid  <= 1'b0;
      lsu_result <= 32'h0;
      lsu_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (alu_valid) begin
            f3_q  <= funct3;
            a_q   <= a_in;
            ren_q <= mem_ren;
            if (!mem_ren && !mem_wen) begin
              lsu_result <= alu_result;
              lsu_err    <= 1'b0;
              lsu_valid  <= 1'b1;
              state      <= DONE;
            end else if (op_err) begin
              lsu_result <= 32'h0;
              lsu_err    <= 1'b1;
              lsu_valid  <= 1'b1;
              state      <= DONE;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= mem_wen;
              mem_addr  <= {alu_result[31:2], 2'b00};
              mem_wdata <= wdata_in;
              mem_wmask <= wmask_in;
              cnt       <= '0;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            lsu_result <= ren_q ? load_val : 32'h0;
            lsu_err    <= 1'b0;
            lsu_valid  <= 1'b1;
            state      <= DONE;
          end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
            mem_req    <= 1'b0;
            lsu_result <= 32'h0;
            lsu_err    <= 1'b1;
            lsu_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          lsu_valid <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          lsu_valid <= 1'b0;
          mem_req   <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
